// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer around the RV32I ALU: decode, operand fetch, one ALU_EN pulse, writeback.
// Optional retire/illegal counters are compiled in with ALU_ISSUE_SEQ_RETIRE_CNT_EN.
module alu_issue_seq #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_func,
  output logic [6:0]      alu_opcode,
  output logic            alu_en,
  input  logic [XLEN-1:0] alu_y,
  output logic            done,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_cnt,
  output logic [15:0]     illegal_cnt
`endif
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_SLL = 3'b101;
  localparam logic [2:0] F_SRL = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic            legal;
    logic [2:0]      func;
    logic [XLEN-1:0] b;
  } dec_t;

  state_t          state, state_nxt;
  logic [31:0]     instr;
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rs1_val, rs2_val;
  dec_t            dec;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

  // Decode of the latched instruction; only meaningful while in DECODE.
  always_comb begin
    dec       = '0;
    dec.legal = (opcode == OP_R) || (opcode == OP_I);
    dec.b     = (opcode == OP_R) ? rs2_val : {{(XLEN-12){instr[31]}}, instr[31:20]};
    case (funct3)
      3'b000: begin
        if (opcode == OP_R && funct7 == 7'b0100000) dec.func = F_SUB;
        else if (opcode == OP_R && funct7 != 7'b0000000) dec.legal = 1'b0;
        else dec.func = F_ADD;
      end
      3'b111: dec.func = F_AND;
      3'b110: dec.func = F_OR;
      3'b100: dec.func = F_XOR;
      3'b001: begin
        dec.func = F_SLL;
        if (funct7 != 7'b0000000) dec.legal = 1'b0;
      end
      3'b101: begin
        dec.func = F_SRL;
        if (funct7 != 7'b0000000) dec.legal = 1'b0;
      end
      default: dec.legal = 1'b0;
    endcase
    // Immediate shifts carry only the 5-bit shamt; upper imm bits are funct7.
    if (opcode == OP_I && (funct3 == 3'b001 || funct3 == 3'b101))
      dec.b = {{(XLEN-5){1'b0}}, instr[24:20]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = dec.legal ? S_EXEC : S_IDLE;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs straight off the state register, so reset clears them asynchronously.
  always_comb begin
    in_ready = (state == S_IDLE);
    alu_en   = (state == S_EXEC);
    done     = (state == S_WB);
    illegal  = (state == S_DECODE) && !dec.legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      alu_opcode <= '0;
    end else begin
      if (state == S_IDLE && in_valid) instr <= in_instr;
      if (state == S_DECODE && dec.legal) begin
        alu_a      <= rs1_val;
        alu_b      <= dec.b;
        alu_func   <= dec.func;
        alu_opcode <= opcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (state == S_WB && rd != 5'd0) begin
      rf[rd] <= alu_y;
    end
  end

`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (done) retire_cnt <= retire_cnt + 32'd1;
      if (illegal && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Multi-cycle issue/writeback sequencer placed directly upstream and downstream of the RV32I ALU in the non-pipelined core.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes R-type and I-type arithmetic.
- Reads operands from an internal 32x32 register file, drives the ALU operand, func and opcode inputs, pulses ALU_EN, captures Y and writes it back to rd.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction valid.
- in_ready  output  1  sequencer can accept an instruction.
- in_instr  input  32  RV32I instruction word.
- alu_a  output  32  ALU operand A.
- alu_b  output  32  ALU operand B.
- alu_func  output  3  ALU func code.
- alu_opcode  output  7  ALU opcode (instr[6:0]).
- alu_en  output  1  ALU enable; the ALU evaluates on its rising edge.
- alu_y  input  32  ALU result.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse when an instruction is rejected.
- dbg_addr  input  5  debug register read address.
- dbg_data  output  32  combinational read of regfile[dbg_addr]; always 0 for x0.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs are 0, except in_ready = 1 in IDLE.
  - All registers are cleared to 0.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch in_instr and go to DECODE.
  - in_ready is 0 in every other state.
- DECODE:
  - Register alu_a = rf[rs1].
  - Register alu_opcode = instr[6:0].
  - Register alu_b:
    - R-type (0110011): rf[rs2].
    - I-type (0010011): sign-extended instr[31:20]; for shifts, zero-extended shamt instr[24:20].
- func map, R-type (funct3 / funct7 -> alu_func):
  - 000 / 0000000 -> ADD 000.
  - 000 / 0100000 -> SUB 001.
  - 111 -> AND 010.
  - 110 -> OR 011.
  - 100 -> XOR 100.
  - 001 / 0000000 -> SLL 101.
  - 101 / 0000000 -> SRL 110.
- func map, I-type: same mapping; SUB has no I form, so funct3 000 always maps to ADD.
- Illegal instructions:
  - Any other opcode/funct combination, including SRA/SLT/SLTU and loads/stores, is illegal.
  - On illegal: pulse illegal for one cycle, perform no ALU enable and no write, return to IDLE.
- EXEC:
  - alu_en = 1 for exactly one cycle.
  - alu_a, alu_b, alu_func and alu_opcode have been stable since DECODE and hold until the next DECODE.
- WB:
  - Sample alu_y and write rf[rd] on this edge, unless rd = 0.
  - alu_en returns to 0.
  - done pulses for one cycle.
- Latency: accept at edge N, done high during cycle N+3, in_ready high again in cycle N+4. Throughput is one instruction per 4 cycles.
- Dependencies: none need handling. The next instruction reads in its DECODE, which is after the previous WB write.
- x0: writes are discarded and reads return 0, including rd = rs1 = 0.
- Reset mid-operation: the instruction is abandoned and no write occurs. If alu_en is high it drops to 0 immediately (asynchronous).
- Width: results are truncated to XLEN, with no overflow flag. Shift amount is the ALU's concern; the sequencer passes it unmodified.

Optional Feature:
- Macro: ALU_ISSUE_SEQ_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt[31:0], which increments by 1 on every done pulse and wraps 0xFFFFFFFF -> 0.
  - Adds output illegal_cnt[15:0], which increments on every illegal pulse and saturates at 0xFFFF.
  - Both counters reset to 0.
- When undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Reset, then dbg_addr sweep 0..31 -> dbg_data = 0 for all; in_ready = 1; alu_en = 0.
- ADDI x1,x0,5 then ADDI x2,x0,-3 (imm 0xFFD) then ADD x3,x1,x2:
  - dbg x3 = 2.
  - alu_b during ADDI x2 = 0xFFFFFFFD.
  - done exactly 3 cycles after each accept.
- SUB x4,x2,x1 (-3 - 5) -> x4 = 0xFFFFFFF8; alu_func = 001 during EXEC.
- SLLI x5,x1,4 -> x5 = 0x50, alu_b = 4. ADDI x0,x0,7 -> x0 still reads 0, done still pulses.
- Opcode 0000011 (load) and R-type funct3 010 (SLT):
  - illegal pulses once for each.
  - No alu_en.
  - Regfile unchanged.
  - in_ready back 2 cycles after accept.
- Deassert rst_n during EXEC of ADDI x6,x0,9:
  - alu_en drops immediately.
  - x6 = 0 after release.
  - With the macro defined, retire_cnt = 0 after reset and equals the retired count in prior scenarios.
